uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small word FIFO in front of the serialiser.
// Queued words go out as back-to-back frames: start, data LSB first, optional parity, stop bits.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_BITS-1:0]               inData,
    input  logic                               inValid,
    output logic                               inReady,
    output logic                               outTx,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifoCount
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   div_last;
    logic [DATA_BITS-1:0]   head;
    logic                   head_par;

    assign inReady   = (count_q != CNT_W'(FIFO_DEPTH));
    assign push      = inValid && inReady;
    assign div_last  = (div_q == DIV_W'(CLK_DIV - 1));
    assign head      = mem[rd_ptr_q];
    // Odd parity makes the total count of ones odd, so it is the inverted XOR reduction.
    assign head_par  = (PARITY == 1) ? ~(^head) : (^head);

    assign outTx     = tx_q;
    assign busy      = (state_q != S_IDLE);
    assign fifoCount = count_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;

        if (state_q != S_IDLE) begin
            div_d = div_last ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                div_d = '0;
                bit_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (div_last) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (div_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (div_last) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (div_last) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        // A waiting word starts immediately, with no idle bit between frames.
                        if (count_q != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            tx_d    = 1'b0;
                            state_d = S_START;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= inData;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 8E1, 8O2) at CLK_DIV=4.
// Directed thread resumes at posedge+1; all DUT outputs are sampled on negedges.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data  [3];
    logic       in_valid [3];
    logic       in_ready [3];
    logic       tx       [3];
    logic       busy_w   [3];
    logic [2:0] count_w  [3];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8n1 (
        .clk(clk), .reset(reset), .inData(in_data[0]), .inValid(in_valid[0]), .inReady(in_ready[0]),
        .outTx(tx[0]), .busy(busy_w[0]), .fifoCount(count_w[0]));

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_8e1 (
        .clk(clk), .reset(reset), .inData(in_data[1]), .inValid(in_valid[1]), .inReady(in_ready[1]),
        .outTx(tx[1]), .busy(busy_w[1]), .fifoCount(count_w[1]));

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_8o2 (
        .clk(clk), .reset(reset), .inData(in_data[2]), .inValid(in_valid[2]), .inReady(in_ready[2]),
        .outTx(tx[2]), .busy(busy_w[2]), .fifoCount(count_w[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    // Scoreboard: a handshake seen at the negedge is accepted at the following posedge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (in_valid[0] && in_ready[0]) exp_q0.push_back(in_data[0]);
            if (in_valid[1] && in_ready[1]) exp_q1.push_back(in_data[1]);
            if (in_valid[2] && in_ready[2]) exp_q2.push_back(in_data[2]);
        end
    end

    function automatic int q_size(input int which);
        case (which)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [7:0] q_pop(input int which);
        case (which)
            0:       return exp_q0.pop_front();
            1:       return exp_q1.pop_front();
            default: return exp_q2.pop_front();
        endcase
    endfunction

    // Watches one serial line; every cycle of each frame is compared with the expected bit.
    task automatic monitor(input int which);
        logic [63:0] act_v, exp_v;
        logic [11:0] bits;
        logic [7:0]  w;
        int          nb;
        bit          busy_ok, aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx[which] === 1'b0) begin
                if (q_size(which) == 0) begin
                    check($sformatf("unexpected_frame_dut%0d", which), 64'd1, 64'd0);
                    for (int i = 0; i < 60 && tx[which] !== 1'b1; i++) @(negedge clk);
                end else begin
                    w  = q_pop(which);
                    nb = 0;
                    bits = '0;
                    bits[nb] = 1'b0; nb++;
                    for (int i = 0; i < 8; i++) begin bits[nb] = w[i]; nb++; end
                    if (which == 1) begin bits[nb] = ^w;    nb++; end
                    if (which == 2) begin bits[nb] = ~(^w); nb++; end
                    bits[nb] = 1'b1; nb++;
                    if (which == 2) begin bits[nb] = 1'b1; nb++; end
                    act_v = '0; exp_v = '0; busy_ok = 1'b1; aborted = 1'b0;
                    for (int c = 0; c < nb * CLK_DIV; c++) begin
                        if (c > 0) @(negedge clk);
                        if (reset !== 1'b0) begin aborted = 1'b1; break; end
                        act_v[c] = tx[which];
                        exp_v[c] = bits[c / CLK_DIV];
                        if (busy_w[which] !== 1'b1) busy_ok = 1'b0;
                    end
                    if (!aborted) begin
                        check($sformatf("frame_dut%0d_w%02h", which, w), act_v, exp_v);
                        check($sformatf("frame_busy_dut%0d", which), 64'(busy_ok), 64'd1);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push_word(input int which, input logic [7:0] w);
        bit ok = 1'b0;
        in_data[which]  = w;
        in_valid[which] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready[which]) ok = 1'b1;
            @(posedge clk); #1;
            if (ok) break;
        end
        in_valid[which] = 1'b0;
        if (!ok) check("push_timeout", 64'd0, 64'd1);
    endtask

    // Called at the negedge after the start edge; counts busy cycles, samples cycle 37.
    task automatic measure(input int which, output int len, output logic b9);
        len = 0;
        b9  = 1'bx;
        for (int i = 0; i < 300; i++) begin
            if (busy_w[which] !== 1'b1) break;
            if (len == 37) b9 = tx[which];
            len++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int         which;
        logic [7:0] data;
        int         len;
        logic       bit9;
    } vec_t;

    vec_t tbl [7];
    int   len;
    logic b9;
    int   low_cnt, peak, first_stall, n_acc, viol;
    bit   acc, prev_ready, drained;
    logic [2:0] seq [3];

    initial begin
        // dut, word, busy cycles, line level in cycle 37 (parity slot, or stop bit for 8N1)
        tbl[0] = '{0, 8'hA5, 40, 1'b1};
        tbl[1] = '{1, 8'h07, 44, 1'b1};
        tbl[2] = '{2, 8'h07, 48, 1'b0};
        tbl[3] = '{0, 8'h3C, 40, 1'b1};
        tbl[4] = '{1, 8'h00, 44, 1'b0};
        tbl[5] = '{2, 8'hFF, 48, 1'b1};
        tbl[6] = '{1, 8'h80, 44, 1'b1};

        for (int i = 0; i < 3; i++) begin
            in_data[i]  = '0;
            in_valid[i] = 1'b0;
        end

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outTx", 64'(tx[0]), 64'd1);
        check("rst_busy", 64'(busy_w[0]), 64'd0);
        check("rst_inReady", 64'(in_ready[0]), 64'd1);
        check("rst_fifoCount", 64'(count_w[0]), 64'd0);
        check("rst_outTx_8o2", 64'(tx[2]), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        low_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || tx[1] !== 1'b1 || tx[2] !== 1'b1) low_cnt++;
        end
        check("idle_line_high", 64'(low_cnt), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            push_word(tbl[i].which, tbl[i].data);
            @(negedge clk);
            check($sformatf("t%0d_pre_start_tx", i), 64'(tx[tbl[i].which]), 64'd1);
            check($sformatf("t%0d_count_1", i), 64'(count_w[tbl[i].which]), 64'd1);
            @(negedge clk);
            check($sformatf("t%0d_start_tx", i), 64'(tx[tbl[i].which]), 64'd0);
            check($sformatf("t%0d_start_busy", i), 64'(busy_w[tbl[i].which]), 64'd1);
            measure(tbl[i].which, len, b9);
            check($sformatf("t%0d_busy_len", i), 64'(len), 64'(tbl[i].len));
            check($sformatf("t%0d_bit9", i), 64'(b9), 64'(tbl[i].bit9));
            @(posedge clk); #1;
            repeat (3) @(posedge clk);
            #1;
        end

        // Back-to-back: three consecutive pushes into the 8N1 instance.
        in_valid[0] = 1'b1; in_data[0] = 8'h01;
        @(posedge clk); #1; in_data[0] = 8'h02;
        @(negedge clk); seq[0] = count_w[0];
        @(posedge clk); #1; in_data[0] = 8'h03;
        @(negedge clk); seq[1] = count_w[0];
        len = (busy_w[0] === 1'b1) ? 1 : 0;
        @(posedge clk); #1; in_valid[0] = 1'b0;
        @(negedge clk); seq[2] = count_w[0];
        check("b2b_count0", 64'(seq[0]), 64'd1);
        check("b2b_count1", 64'(seq[1]), 64'd1);
        check("b2b_count2", 64'(seq[2]), 64'd2);
        peak = 2;
        for (int i = 0; i < 300; i++) begin
            if (busy_w[0] !== 1'b1) break;
            if (int'(count_w[0]) > peak) peak = int'(count_w[0]);
            len++;
            @(negedge clk);
        end
        check("b2b_busy_len", 64'(len), 64'd120);
        check("b2b_peak", 64'(peak), 64'd2);
        check("b2b_drained", 64'(count_w[0]), 64'd0);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: inValid held high with ten distinct words.
        n_acc = 0; first_stall = -1; viol = 0; prev_ready = 1'b1;
        in_valid[0] = 1'b1;
        in_data[0]  = {4'h1, 4'($urandom_range(0, 15))};
        for (int i = 0; i < 2000 && n_acc < 10; i++) begin
            @(negedge clk);
            acc = in_ready[0];
            if (in_ready[0] !== (count_w[0] != 3'd4)) viol++;
            if (!in_ready[0] && first_stall < 0) first_stall = n_acc;
            if (!prev_ready && in_ready[0] && count_w[0] != 3'd3) viol++;
            prev_ready = in_ready[0];
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                in_data[0] = {4'(n_acc + 1), 4'($urandom_range(0, 15))};
            end
        end
        in_valid[0] = 1'b0;
        check("bp_accepted", 64'(n_acc), 64'd10);
        check("bp_first_stall", 64'(first_stall), 64'd5);
        check("bp_ready_rule", 64'(viol), 64'd0);
        drained = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy_w[0] === 1'b0 && count_w[0] == 3'd0 && exp_q0.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("bp_all_sent", 64'(drained), 64'd1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of data bit 2 with two words still queued.
        in_valid[0] = 1'b1; in_data[0] = 8'h11;
        @(posedge clk); #1; in_data[0] = 8'h22;
        @(posedge clk); #1; in_data[0] = 8'h33;
        @(posedge clk); #1; in_valid[0] = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("mid_count_2", 64'(count_w[0]), 64'd2);
        check("mid_busy", 64'(busy_w[0]), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q0.delete();
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_outTx", 64'(tx[0]), 64'd1);
        check("mid_rst_busy", 64'(busy_w[0]), 64'd0);
        check("mid_rst_count", 64'(count_w[0]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        low_cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy_w[0] !== 1'b0) low_cnt++;
        end
        check("post_rst_quiet", 64'(low_cnt), 64'd0);
        @(posedge clk); #1;
        push_word(0, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_start", 64'(tx[0]), 64'd0);
        measure(0, len, b9);
        check("post_rst_len", 64'(len), 64'd40);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
